// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: writeback/scoreboard bundle between sources, decode, arbiter and register file
//   master: drives source requests (a_*, b_*), issue (iss_*) and decode read addresses (adr1/adr2)
//   slave : drives a_rdy/b_rdy, busy1/busy2, register-file write (awr/din/wr_en) and bypass (fwd*)
interface rf_write_arbiter_if #(parameter int DATA_W = 32, parameter int ADDR_W = 5);
   logic              a_vld, a_rdy, b_vld, b_rdy, iss_vld;
   logic [ADDR_W-1:0] a_adr, b_adr, iss_adr, adr1, adr2, awr;
   logic [DATA_W-1:0] a_data, b_data, din, fwd1_data, fwd2_data;
   logic              busy1, busy2, wr_en, fwd1_vld, fwd2_vld;
   modport master (
      output a_vld, a_adr, a_data, b_vld, b_adr, b_data, iss_vld, iss_adr, adr1, adr2,
      input  a_rdy, b_rdy, busy1, busy2, awr, din, wr_en, fwd1_vld, fwd1_data, fwd2_vld, fwd2_data
   );
   modport slave (
      input  a_vld, a_adr, a_data, b_vld, b_adr, b_data, iss_vld, iss_adr, adr1, adr2,
      output a_rdy, b_rdy, busy1, busy2, awr, din, wr_en, fwd1_vld, fwd1_data, fwd2_vld, fwd2_data
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin share of the register-file write port between ALU (A) and load (B) with RAW scoreboard
//   clk, rst : clock, synchronous active-high reset
//   bus      : rf_write_arbiter_if.slave (requests, issue, read addrs in; rdy, busy, write port, bypass out)
//   RF_BYPASS_EN defined: fwd1/fwd2 forward the in-flight write; undefined: fwd outputs tied to 0
module rf_write_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input logic               clk,
   input logic               rst,
   rf_write_arbiter_if.slave bus
);
   typedef enum logic {PRI_A, PRI_B} state_t;
   state_t                 state, state_n;
   logic                   grant_a, grant_b, grant;
   logic [ADDR_W-1:0]      g_adr;
   logic [DATA_W-1:0]      g_data;
   logic [2**ADDR_W-1:0]   busy, busy_n;
   always_ff @(posedge clk)
      state <= rst ? PRI_A : state_n;
   // No grants while in reset so sources never see a transfer that gets squashed
   always_comb begin
      grant_a = !rst && bus.a_vld && (!bus.b_vld || state == PRI_A);
      grant_b = !rst && bus.b_vld && !grant_a;
      grant   = grant_a || grant_b;
      g_adr   = grant_a ? bus.a_adr : bus.b_adr;
      g_data  = grant_a ? bus.a_data : bus.b_data;
      state_n = grant_a ? PRI_B : grant_b ? PRI_A : state;
   end
   assign bus.a_rdy = grant_a;
   assign bus.b_rdy = grant_b;
   // R0 writes are accepted but dropped; awr/din hold their last real write
   always_ff @(posedge clk)
      if (rst) begin
         bus.wr_en <= 1'b0;
         bus.awr   <= '0;
         bus.din   <= '0;
      end else begin
         bus.wr_en <= grant && g_adr != '0;
         if (grant && g_adr != '0) begin
            bus.awr <= g_adr;
            bus.din <= g_data;
         end
      end
   // Clear first so a same-cycle issue to the retiring register keeps it busy
   always_comb begin
      busy_n = busy;
      if (bus.wr_en) busy_n[bus.awr] = 1'b0;
      if (bus.iss_vld && bus.iss_adr != '0) busy_n[bus.iss_adr] = 1'b1;
      busy_n[0] = 1'b0;
   end
   always_ff @(posedge clk)
      busy <= rst ? '0 : busy_n;
   assign bus.busy1 = busy[bus.adr1];
   assign bus.busy2 = busy[bus.adr2];
`ifdef RF_BYPASS_EN
   assign bus.fwd1_vld  = bus.wr_en && bus.awr == bus.adr1 && bus.adr1 != '0;
   assign bus.fwd2_vld  = bus.wr_en && bus.awr == bus.adr2 && bus.adr2 != '0;
   assign bus.fwd1_data = bus.din;
   assign bus.fwd2_data = bus.din;
`else
   assign bus.fwd1_vld  = 1'b0;
   assign bus.fwd2_vld  = 1'b0;
   assign bus.fwd1_data = '0;
   assign bus.fwd2_data = '0;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed and randomized checks of rf_write_arbiter against a behavioural model
module tb_rf_write_arbiter;
   localparam int DW = 32;
   localparam int AW = 5;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   rf_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
   rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
   int n_cmp = 0;
   int n_err = 0;
   int prio;
   bit m_init = 0;
   bit m_wr;
   int m_awr;
   logic [DW-1:0] m_din;
   bit m_busy [32];
   bit last_ga, last_gb;
   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      bit ga, gb, f1, f2;
      int wa;
      logic [DW-1:0] wd, fd;
      #1;
      if (rst) begin
         ga = 0; gb = 0;
      end else if (bus.a_vld && bus.b_vld) begin
         ga = (prio == 0); gb = (prio == 1);
      end else begin
         ga = bus.a_vld; gb = bus.b_vld;
      end
      check("a_rdy", bus.a_rdy, ga);
      check("b_rdy", bus.b_rdy, gb);
      if (m_init) begin
`ifdef RF_BYPASS_EN
         f1 = m_wr && m_awr == int'(bus.adr1) && bus.adr1 != 0;
         f2 = m_wr && m_awr == int'(bus.adr2) && bus.adr2 != 0;
         fd = m_din;
`else
         f1 = 0; f2 = 0; fd = '0;
`endif
         check("wr_en", bus.wr_en, m_wr);
         check("awr", bus.awr, m_awr);
         check("din", bus.din, m_din);
         check("busy1", bus.busy1, m_busy[bus.adr1]);
         check("busy2", bus.busy2, m_busy[bus.adr2]);
         check("fwd1_vld", bus.fwd1_vld, f1);
         check("fwd2_vld", bus.fwd2_vld, f2);
         check("fwd1_data", bus.fwd1_data, fd);
         check("fwd2_data", bus.fwd2_data, fd);
      end
      last_ga = ga;
      last_gb = gb;
      if (rst) begin
         m_init = 1; prio = 0; m_wr = 0; m_awr = 0; m_din = '0;
         foreach (m_busy[i]) m_busy[i] = 0;
      end else begin
         if (m_wr) m_busy[m_awr] = 0;
         if (bus.iss_vld && bus.iss_adr != 0) m_busy[bus.iss_adr] = 1;
         if (ga || gb) begin
            wa = ga ? int'(bus.a_adr) : int'(bus.b_adr);
            wd = ga ? bus.a_data : bus.b_data;
            m_wr = (wa != 0);
            if (wa != 0) begin
               m_awr = wa;
               m_din = wd;
            end
            prio = ga ? 1 : 0;
         end else m_wr = 0;
      end
      @(negedge clk);
   endtask
   initial begin
      rst = 1;
      bus.a_vld = 0; bus.a_adr = '0; bus.a_data = '0;
      bus.b_vld = 0; bus.b_adr = '0; bus.b_data = '0;
      bus.iss_vld = 0; bus.iss_adr = '0; bus.adr1 = '0; bus.adr2 = '0;
      @(negedge clk);
      bus.a_vld = 1; bus.a_adr = 5'd3; bus.a_data = 32'h11;
      bus.b_vld = 1; bus.b_adr = 5'd4; bus.b_data = 32'h22;
      tick();
      tick();
      check("rst_wr_en", bus.wr_en, 0);
      check("rst_awr", bus.awr, 0);
      check("rst_din", bus.din, 0);
      check("rst_busy1", bus.busy1, 0);
      check("rst_a_rdy", bus.a_rdy, 0);
      check("rst_b_rdy", bus.b_rdy, 0);
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("cont_grant_a", last_ga, (i % 2) == 0);
         check("cont_awr", bus.awr, (i % 2) == 0 ? 3 : 4);
         check("cont_din", bus.din, (i % 2) == 0 ? 32'h11 : 32'h22);
      end
      bus.a_vld = 0; bus.b_vld = 0;
      tick();
      bus.a_vld = 1; bus.a_adr = 5'd5; bus.a_data = 32'hDEADBEEF;
      tick();
      bus.a_vld = 0;
      check("single_rdy", last_ga, 1);
      check("single_wr_en", bus.wr_en, 1);
      check("single_awr", bus.awr, 5);
      check("single_din", bus.din, 32'hDEADBEEF);
      bus.b_vld = 1; bus.b_adr = 5'd0; bus.b_data = 32'hFFFF;
      tick();
      bus.b_vld = 0;
      check("r0_rdy", last_gb, 1);
      check("r0_wr_en", bus.wr_en, 0);
      check("r0_din_hold", bus.din, 32'hDEADBEEF);
      bus.iss_vld = 1; bus.iss_adr = 5'd7; bus.adr1 = 5'd7;
      tick();
      bus.iss_vld = 0;
      check("sb_set", bus.busy1, 1);
      bus.a_vld = 1; bus.a_adr = 5'd7; bus.a_data = 32'h77;
      tick();
      bus.a_vld = 0;
      check("sb_during_wr", bus.busy1, 1);
      tick();
      check("sb_clear", bus.busy1, 0);
      bus.iss_vld = 1;
      tick();
      bus.iss_vld = 0;
      bus.a_vld = 1;
      tick();
      bus.a_vld = 0;
      bus.iss_vld = 1;
      tick();
      bus.iss_vld = 0;
      check("sb_set_wins", bus.busy1, 1);
      bus.a_vld = 1; bus.a_adr = 5'd9; bus.a_data = 32'h55;
      tick();
      bus.a_vld = 0;
      bus.adr2 = 5'd9;
      #1;
`ifdef RF_BYPASS_EN
      check("byp_vld", bus.fwd2_vld, 1);
      check("byp_data", bus.fwd2_data, 32'h55);
`else
      check("byp_off_vld", bus.fwd2_vld, 0);
`endif
      bus.adr2 = 5'd0;
      #1;
      check("byp_r0", bus.fwd2_vld, 0);
      tick();
      for (int i = 0; i < 3000; i++) begin
         if (!bus.a_vld || last_ga) begin
            bus.a_vld = 1'($urandom_range(0, 1));
            bus.a_adr = 5'($urandom_range(0, 9));
            bus.a_data = $urandom;
         end
         if (!bus.b_vld || last_gb) begin
            bus.b_vld = 1'($urandom_range(0, 1));
            bus.b_adr = 5'($urandom_range(0, 9));
            bus.b_data = $urandom;
         end
         bus.iss_vld = 1'($urandom_range(0, 1));
         bus.iss_adr = 5'($urandom_range(0, 9));
         bus.adr1 = 5'($urandom_range(0, 9));
         bus.adr2 = 5'($urandom_range(0, 9));
         rst = ($urandom_range(0, 99) == 0);
         tick();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
